// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-port signals between the mem_arbiter and its clients.
// The arbiter takes the slave modport; the requesters plus RAM take the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic                  lsb_req;
  logic                  lsb_wr;
  logic [1:0]            lsb_size;
  logic [ADDR_WIDTH-1:0] lsb_addr;
  logic [31:0]           lsb_wdata;
  logic                  lsb_done;
  logic [31:0]           lsb_rdata;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  if_req, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and the load/store buffer.
// Each request is split into 1/2/4 byte beats; reads assemble little-endian, writes stream low byte first.
module mem_arbiter #(
  parameter int         ADDR_WIDTH   = 32,
  parameter logic [1:0] IO_ADDR_MASK = 2'b11
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_LSB = 1'b1;

  state_t                r_state,      w_state_next;
  logic                  r_last_grant, w_last_grant_next;
  logic [1:0]            r_cnt,        w_cnt_next;
  logic [1:0]            r_last,       w_last_next;
  logic [31:0]           r_wdata,      w_wdata_next;
  logic [31:0]           r_buf,        w_buf_next;
  logic                  r_if_done,    w_if_done_next;
  logic                  r_lsb_done,   w_lsb_done_next;
  logic [31:0]           r_if_data,    w_if_data_next;
  logic [31:0]           r_lsb_rdata,  w_lsb_rdata_next;
  logic [7:0]            r_mem_dout,   w_mem_dout_next;
  logic [ADDR_WIDTH-1:0] r_mem_a,      w_mem_a_next;
  logic                  r_mem_wr,     w_mem_wr_next;

  logic       w_if_ok;
  logic       w_lsb_ok;
  logic       w_grant_lsb;
  logic       w_grant_if;
  logic [1:0] w_lsb_last;

  // A store into the IO window must wait while the IO write queue is full.
  assign w_lsb_ok    = bus.lsb_req &&
                       !(bus.lsb_wr && (bus.lsb_addr[17:16] == IO_ADDR_MASK) && bus.io_buffer_full);
  assign w_if_ok     = bus.if_req && !flush_in;
  assign w_grant_lsb = w_lsb_ok && (!w_if_ok || (r_last_grant == GRANT_IF));
  assign w_grant_if  = w_if_ok && !w_grant_lsb;

  always_comb begin
    case (bus.lsb_size)
      2'b00:   w_lsb_last = 2'd0;
      2'b01:   w_lsb_last = 2'd1;
      default: w_lsb_last = 2'd3;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_cnt_next        = r_cnt;
    w_last_next       = r_last;
    w_wdata_next      = r_wdata;
    w_buf_next        = r_buf;
    w_if_done_next    = r_if_done;
    w_lsb_done_next   = r_lsb_done;
    w_if_data_next    = r_if_data;
    w_lsb_rdata_next  = r_lsb_rdata;
    w_mem_dout_next   = r_mem_dout;
    w_mem_a_next      = r_mem_a;
    w_mem_wr_next     = r_mem_wr;

    // With rdy_in low everything, including a pending done pulse, simply holds.
    if (rdy_in) begin
      w_if_done_next  = 1'b0;
      w_lsb_done_next = 1'b0;
      case (r_state)
        IDLE: begin
          w_mem_wr_next = 1'b0;
          if (w_grant_lsb) begin
            w_state_next      = bus.lsb_wr ? LS_WR : LS_RD;
            w_last_grant_next = GRANT_LSB;
            w_mem_a_next      = bus.lsb_addr;
            w_cnt_next        = 2'd0;
            w_last_next       = w_lsb_last;
            w_buf_next        = 32'h0;
            w_mem_wr_next     = bus.lsb_wr;
            w_mem_dout_next   = bus.lsb_wr ? bus.lsb_wdata[7:0] : 8'h00;
            w_wdata_next      = {8'h00, bus.lsb_wdata[31:8]};
          end else if (w_grant_if) begin
            w_state_next      = IF_RD;
            w_last_grant_next = GRANT_IF;
            w_mem_a_next      = bus.if_addr;
            w_cnt_next        = 2'd0;
            w_last_next       = 2'd3;
            w_buf_next        = 32'h0;
          end
        end
        IF_RD: begin
          if (flush_in) begin
            w_state_next = IDLE;
            w_mem_a_next = '0;
          end else begin
            w_buf_next[{r_cnt, 3'b000} +: 8] = bus.mem_din;
            if (r_cnt == r_last) begin
              w_state_next   = IDLE;
              w_if_done_next = 1'b1;
              w_if_data_next = w_buf_next;
            end else begin
              w_cnt_next   = r_cnt + 2'd1;
              w_mem_a_next = r_mem_a + 1'b1;
            end
          end
        end
        LS_RD: begin
          w_buf_next[{r_cnt, 3'b000} +: 8] = bus.mem_din;
          if (r_cnt == r_last) begin
            w_state_next     = IDLE;
            w_lsb_done_next  = 1'b1;
            w_lsb_rdata_next = w_buf_next;
          end else begin
            w_cnt_next   = r_cnt + 2'd1;
            w_mem_a_next = r_mem_a + 1'b1;
          end
        end
        LS_WR: begin
          if (r_cnt == r_last) begin
            w_state_next    = IDLE;
            w_mem_wr_next   = 1'b0;
            w_lsb_done_next = 1'b1;
          end else begin
            w_cnt_next      = r_cnt + 2'd1;
            w_mem_a_next    = r_mem_a + 1'b1;
            w_mem_wr_next   = 1'b1;
            w_mem_dout_next = r_wdata[7:0];
            w_wdata_next    = {8'h00, r_wdata[31:8]};
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_IF;
      r_cnt        <= 2'd0;
      r_last       <= 2'd0;
      r_wdata      <= 32'h0;
      r_buf        <= 32'h0;
      r_if_done    <= 1'b0;
      r_lsb_done   <= 1'b0;
      r_if_data    <= 32'h0;
      r_lsb_rdata  <= 32'h0;
      r_mem_dout   <= 8'h00;
      r_mem_a      <= '0;
      r_mem_wr     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_cnt        <= w_cnt_next;
      r_last       <= w_last_next;
      r_wdata      <= w_wdata_next;
      r_buf        <= w_buf_next;
      r_if_done    <= w_if_done_next;
      r_lsb_done   <= w_lsb_done_next;
      r_if_data    <= w_if_data_next;
      r_lsb_rdata  <= w_lsb_rdata_next;
      r_mem_dout   <= w_mem_dout_next;
      r_mem_a      <= w_mem_a_next;
      r_mem_wr     <= w_mem_wr_next;
    end
  end

  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.lsb_done  = r_lsb_done;
  assign bus.lsb_rdata = r_lsb_rdata;
  assign bus.mem_dout  = r_mem_dout;
  assign bus.mem_a     = r_mem_a;
  assign bus.mem_wr    = r_mem_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration, stores, IO back-pressure, flush, reset and rdy stalls.
// Expected read data and RAM writes are queued when stimulus is applied and consumed by output monitors.
module tb_mem_arbiter;
  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } lsb_exp_t;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush_in;
  logic rdy_q = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [7:0]  ram [0:65535];
  logic [31:0] if_q [$];
  lsb_exp_t    lsb_q [$];
  logic [39:0] wr_q [$];
  logic [31:0] e_if;
  lsb_exp_t    e_lsb;
  logic [39:0] e_wr;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .IO_ADDR_MASK(2'b11)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_din = ram[bus.mem_a[15:0]];

  // A done or write seen after an edge where rdy_in was high is a new event, not a held one.
  always @(posedge clk) rdy_q <= rdy_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_done"},   {31'h0, bus.if_done},  32'h0);
    chk({tag, "_lsb_done"},  {31'h0, bus.lsb_done}, 32'h0);
    chk({tag, "_if_data"},   bus.if_data,           32'h0);
    chk({tag, "_lsb_rdata"}, bus.lsb_rdata,         32'h0);
    chk({tag, "_mem_dout"},  {24'h0, bus.mem_dout}, 32'h0);
    chk({tag, "_mem_a"},     bus.mem_a,             32'h0);
    chk({tag, "_mem_wr"},    {31'h0, bus.mem_wr},   32'h0);
  endtask

  always @(negedge clk) begin
    if (bus.if_done && rdy_q) begin
      chk("if_done_expected", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) begin
        e_if = if_q.pop_front();
        $display("fetch done   data=%h expect=%h", bus.if_data, e_if);
        chk("if_data", bus.if_data, e_if);
      end
    end
    if (bus.lsb_done && rdy_q) begin
      chk("lsb_done_expected", 32'(lsb_q.size() != 0), 32'd1);
      if (lsb_q.size() != 0) begin
        e_lsb = lsb_q.pop_front();
        $display("lsb done     store=%0d rdata=%h expect=%h", e_lsb.wr, bus.lsb_rdata, e_lsb.data);
        if (!e_lsb.wr) chk("lsb_rdata", bus.lsb_rdata, e_lsb.data);
      end
    end
    if (bus.mem_wr && rdy_q) begin
      chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e_wr = wr_q.pop_front();
        $display("ram write    a=%h d=%h expect a=%h d=%h", bus.mem_a, bus.mem_dout, e_wr[39:8], e_wr[7:0]);
        chk("wr_addr", bus.mem_a, e_wr[39:8]);
        chk("wr_data", {24'h0, bus.mem_dout}, {24'h0, e_wr[7:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
    ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22; ram[16'h2002] = 8'h33; ram[16'h2003] = 8'h44;
    ram[16'h4000] = 8'hB7; ram[16'h4001] = 8'h12; ram[16'h4002] = 8'h34; ram[16'h4003] = 8'h56;

    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b00;
    bus.lsb_addr = 32'h0; bus.lsb_wdata = 32'h0; bus.io_buffer_full = 1'b0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_in = 1'b1;
    @(negedge clk);

    // Plain word fetch
    if_q.push_back(32'h00100513);
    bus.if_addr = 32'h1000; bus.if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_mem_a", bus.mem_a, 32'h1000 + 32'(k));
      chk("fetch_early_done", {31'h0, bus.if_done}, 32'h0);
    end
    @(negedge clk);
    chk("fetch_done_lat4", {31'h0, bus.if_done}, 32'h1);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Both pending with last grant = IF: LSB word load first, then the fetch
    lsb_q.push_back('{wr: 1'b0, data: 32'h44332211});
    if_q.push_back(32'h00100513);
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b10; bus.lsb_addr = 32'h2000;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    @(negedge clk);
    chk("arb_lsb_first_a", bus.mem_a, 32'h2000);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("arb_lsb_done", {31'h0, bus.lsb_done}, 32'h1);
    chk("arb_if_not_done", {31'h0, bus.if_done}, 32'h0);
    bus.lsb_req = 1'b0;
    @(negedge clk);
    chk("arb_if_second_a", bus.mem_a, 32'h1000);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("arb_if_done", {31'h0, bus.if_done}, 32'h1);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Half store
    lsb_q.push_back('{wr: 1'b1, data: 32'h0});
    wr_q.push_back({32'h3002, 8'hEF});
    wr_q.push_back({32'h3003, 8'hBE});
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b01;
    bus.lsb_addr = 32'h3002; bus.lsb_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("half_wr_beat0", {31'h0, bus.mem_wr}, 32'h1);
    @(negedge clk);
    chk("half_wr_beat1", {31'h0, bus.mem_wr}, 32'h1);
    @(negedge clk);
    chk("half_wr_end", {31'h0, bus.mem_wr}, 32'h0);
    chk("half_done_lat2", {31'h0, bus.lsb_done}, 32'h1);
    bus.lsb_req = 1'b0;
    @(negedge clk);

    // IO store held back while the IO queue is full; a fetch slips in
    if_q.push_back(32'h00100513);
    lsb_q.push_back('{wr: 1'b1, data: 32'h0});
    wr_q.push_back({32'h30000, 8'h44});
    wr_q.push_back({32'h30001, 8'h33});
    wr_q.push_back({32'h30002, 8'h22});
    wr_q.push_back({32'h30003, 8'h11});
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b10;
    bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'h11223344;
    bus.io_buffer_full = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("io_blocked_wr", {31'h0, bus.mem_wr}, 32'h0);
      if (k == 0) chk("io_fetch_granted", bus.mem_a, 32'h1000);
    end
    chk("io_fetch_done", {31'h0, bus.if_done}, 32'h1);
    bus.if_req = 1'b0; bus.io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io_store_granted_wr", {31'h0, bus.mem_wr}, 32'h1);
    chk("io_store_granted_a", bus.mem_a, 32'h30000);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("io_store_done", {31'h0, bus.lsb_done}, 32'h1);
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0;
    @(negedge clk);

    // Flush in the second cycle of a fetch, then a clean fetch at 0x4000
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    @(negedge clk);
    chk("flush_pre_a", bus.mem_a, 32'h1000);
    flush_in = 1'b1;
    @(negedge clk);
    chk("flush_mem_a_zero", bus.mem_a, 32'h0);
    chk("flush_no_done", {31'h0, bus.if_done}, 32'h0);
    flush_in = 1'b0; bus.if_addr = 32'h4000;
    if_q.push_back(32'h563412B7);
    @(negedge clk);
    chk("refetch_a", bus.mem_a, 32'h4000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("refetch_early_done", {31'h0, bus.if_done}, 32'h0);
    end
    @(negedge clk);
    chk("refetch_done", {31'h0, bus.if_done}, 32'h1);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Reset asserted mid-store: outputs clear at once, no done afterwards
    wr_q.push_back({32'h5000, 8'h0D});
    wr_q.push_back({32'h5001, 8'hF0});
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b10;
    bus.lsb_addr = 32'h5000; bus.lsb_wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_in = 1'b0; bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("postrst_no_done", {31'h0, bus.lsb_done}, 32'h0);
      chk("postrst_no_wr", {31'h0, bus.mem_wr}, 32'h0);
    end

    // rdy_in low for 3 cycles during a word load
    lsb_q.push_back('{wr: 1'b0, data: 32'h44332211});
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b10; bus.lsb_addr = 32'h2000;
    @(negedge clk);
    chk("stall_a0", bus.mem_a, 32'h2000);
    @(negedge clk);
    chk("stall_a1", bus.mem_a, 32'h2001);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_a_frozen", bus.mem_a, 32'h2001);
      chk("stall_no_done", {31'h0, bus.lsb_done}, 32'h0);
    end
    rdy_in = 1'b1;
    @(negedge clk);
    chk("stall_a2", bus.mem_a, 32'h2002);
    @(negedge clk);
    chk("stall_not_yet", {31'h0, bus.lsb_done}, 32'h0);
    @(negedge clk);
    chk("stall_done_lat7", {31'h0, bus.lsb_done}, 32'h1);
    bus.lsb_req = 1'b0;
    @(negedge clk);

    // Byte load whose done pulse is held by rdy_in low
    lsb_q.push_back('{wr: 1'b0, data: 32'h00000044});
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b00; bus.lsb_addr = 32'h2003;
    @(negedge clk);
    chk("byte_not_yet", {31'h0, bus.lsb_done}, 32'h0);
    @(negedge clk);
    chk("byte_done_lat1", {31'h0, bus.lsb_done}, 32'h1);
    rdy_in = 1'b0; bus.lsb_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("byte_done_held", {31'h0, bus.lsb_done}, 32'h1);
      chk("byte_rdata_held", bus.lsb_rdata, 32'h00000044);
    end
    rdy_in = 1'b1;
    @(negedge clk);
    chk("byte_done_cleared", {31'h0, bus.lsb_done}, 32'h0);

    repeat (3) @(negedge clk);
    chk("if_q_drained",  32'(if_q.size()),  32'd0);
    chk("lsb_q_drained", 32'(lsb_q.size()), 32'd0);
    chk("wr_q_drained",  32'(wr_q.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide unified RAM port and shares it between two requesters: the instruction fetcher (32-bit instruction reads) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into byte beats, then returns assembled read data or a write completion with a one-cycle done pulse.
- Handles pipeline flush for fetches and IO write back-pressure.

Parameters:
- ADDR_WIDTH, 32, width of every address bus.
- IO_ADDR_MASK, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- flush_in  input  1  misprediction flush; aborts an in-flight fetch.
- if_req  input  1  fetch request; level, held until if_done.
- if_addr  input  32  fetch byte address.
- if_done  output  1  one-cycle pulse; if_data valid in that cycle.
- if_data  output  32  fetched instruction, little-endian.
- lsb_req  input  1  load/store request; level, held until lsb_done.
- lsb_wr  input  1  1 = store, 0 = load.
- lsb_size  input  2  00 = byte, 01 = half, 10 = word (11 is treated as word).
- lsb_addr  input  32  load/store byte address.
- lsb_wdata  input  32  store data; low bytes are used first.
- lsb_done  output  1  one-cycle completion pulse.
- lsb_rdata  output  32  load data, zero-extended (sign extension happens downstream).
- mem_din  input  8  RAM read byte; returns data for the previous cycle's mem_a.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  RAM write strobe.
- io_buffer_full  input  1  IO write queue full.

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE and last_grant to IF.
  - All outputs go to 0: if_done, lsb_done, if_data, lsb_rdata, mem_dout, mem_a, mem_wr.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- Arbitration in IDLE, evaluated at the clock edge:
  - The LSB request is blocked when lsb_wr=1, lsb_addr[17:16]=IO_ADDR_MASK and io_buffer_full=1.
  - The IF request is blocked when flush_in=1.
  - If only one unblocked request is pending, it is granted.
  - If both are pending, the requester not in last_grant wins. This alternation prevents starvation.
  - A grant updates last_grant.
  - No request, or all pending requests blocked: stay in IDLE with mem_wr=0.
- Beat count N: 4 for a fetch; for the LSB, 1, 2 or 4 per lsb_size.
- Timing, with t0 as the grant edge:
  - At edge t0+k (0 <= k < N), mem_a = base address + k.
  - For a store, that edge also sets mem_wr=1 and mem_dout = wdata byte k.
  - For a read, edges t0+1 through t0+N capture mem_din into result byte k-1 (little-endian; unused upper bytes stay 0).
  - At edge t0+N: mem_wr goes to 0, the matching done pulses high for one cycle with data, and the state returns to IDLE.
  - The earliest next grant is edge t0+N+1.
- Latency, request held at grant edge to done visible:
  - Byte load: 1 cycle.
  - Word fetch or word load: 4 cycles.
  - Word store: 4 cycles.
- Address arithmetic: plain 32-bit increments, wrapping at 0xFFFFFFFF to 0x0.
- No preemption: once an LS_RD or LS_WR transaction starts, it runs to completion; flush_in has no effect on it.
- flush_in high at any edge while in IF_RD:
  - Return to IDLE immediately.
  - mem_a goes to 0; if_done is not pulsed.
  - Partial if_data is discarded.
- Requesters may change addr or req only after done (or after a flush, for IF). Inputs are sampled once, at the grant edge.
- rdy_in low: the state, counter, mem_wr and done pulse all hold. A pending done pulse stays high until rdy_in returns.
- Reset mid-transaction: immediate abort with all outputs 0; no done pulse is ever issued for the aborted request.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x1000, RAM[0x1000..3]=13,05,10,00.
   - Required: mem_a steps 0x1000 to 0x1003.
   - Required: if_done pulses 4 cycles after grant with if_data=0x00100513.
2. Both requesters pending in IDLE with last_grant=IF, lsb word load at 0x2000.
   - Required: LSB is granted first; IF is granted at the next IDLE edge.
   - Required: lsb_done comes before if_done, with no cycle overlap of beats.
3. Half store: lsb_wr=1, lsb_size=01, addr 0x3002, wdata 0xDEADBEEF.
   - Required: mem_wr high for 2 cycles, writing EF to 0x3002 and BE to 0x3003.
   - Required: lsb_done 2 cycles after grant.
4. IO back-pressure: store to 0x30000 with io_buffer_full=1 for 5 cycles.
   - Required: stays IDLE and mem_wr=0 for those 5 cycles; a pending fetch is granted meanwhile.
   - Required: once io_buffer_full drops and the arbiter is back in IDLE, the store is granted at the next edge.
5. Flush: flush_in pulsed in the 2nd cycle of a fetch.
   - Required: no if_done, return to IDLE, then a new fetch at 0x4000 completes normally.
6. Reset/rdy: rst_in low in mid-store, and separately rdy_in low for 3 cycles in mid-load.
   - Required on reset: all outputs are 0 immediately.
   - Required on rdy_in low: mem_a frozen, load completes 3 cycles later than nominal with correct data.
